// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives a 1-cycle-latency imem,
// buffers words with their PCs in a prefetch FIFO for decode.
module fetch_ctrl #(
  parameter int AW    = 11,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [AW-1:0]                start_pc,
  input  logic                         redirect,
  input  logic [AW-1:0]                redirect_pc,
  output logic [AW-1:0]                imem_addr,
  output logic                         imem_rd,
  input  logic [DW-1:0]                imem_q,
  output logic [DW-1:0]                instr_out,
  output logic [AW-1:0]                instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = DW + AW;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_REDIR = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] hold;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          pop;
  logic          push;
  logic          flush;
  logic          can_issue;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign flush = redirect && (state != S_IDLE);
  assign pop   = instr_valid && instr_ready;
  assign push  = inflight && !flush;

  // Credit counts the in-flight word so a full FIFO is never overrun.
  assign occ = {1'b0, count}
             + {{CW{1'b0}}, inflight}
             - {{CW{1'b0}}, pop};

  assign can_issue = (state == S_RUN) && !redirect
                  && (occ < DEPTH_C);

  assign imem_addr   = fetch_pc;
  assign imem_rd     = can_issue;
  assign instr_valid = (count != '0);
  assign fifo_count  = count;
  assign {instr_out, instr_pc} = instr_valid ? mem[rptr] : hold;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (en) state_nxt = S_RUN;
      S_RUN: begin
        if (redirect) state_nxt = S_REDIR;
        else if (!en) state_nxt = S_HALT;
      end
      S_HALT:  if (!redirect && en) state_nxt = S_RUN;
      S_REDIR: if (!redirect) state_nxt = en ? S_RUN : S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= can_issue;
      if (can_issue) inflight_pc <= fetch_pc;
      if (state == S_IDLE) begin
        if (en) fetch_pc <= start_pc;
      end else if (flush) begin
        fetch_pc <= redirect_pc;
      end else if (can_issue) begin
        fetch_pc <= fetch_pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      hold  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (instr_valid) hold <= mem[rptr];
      if (flush) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          mem[wptr] <= {imem_q, inflight_pc};
          wptr      <= inc(wptr);
        end
        if (pop) rptr <= inc(rptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always @(posedge clk)
    if (rst_n)
      assert (!(push && !pop && count == CW'(DEPTH)));

endmodule
